// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient loader: default coefficient width,
// coefficient type and the loader state encoding.
package fir_pkg;

  localparam int DEFAULT_COEFW = 16;

  typedef logic signed [DEFAULT_COEFW-1:0] coef_t;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_PENDING = 2'd1,
    S_DRAIN   = 2'd2
  } load_state_t;

endpackage : fir_pkg

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient storage: single-entry writes into the shadow bank,
// whole-bank copy into the active bank on swap.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int TAPS  = 401,
  parameter int COEFW = DEFAULT_COEFW,
  parameter int IDXW  = $clog2(TAPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [IDXW-1:0]         i_idx,
  input  logic signed [COEFW-1:0] i_data,
  input  logic                    i_swap,
  output logic signed [COEFW-1:0] o_active [0:TAPS-1]
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic signed [COEFW-1:0] r_shadow [0:TAPS-1];
  logic signed [COEFW-1:0] r_active [0:TAPS-1];
  logic [AW-1:0]           w_addr;

  assign w_addr = i_idx[AW-1:0];

  // NOTE: both banks are cleared on reset because the filter consumes the
  // active bank directly and must see zeros, not power-up garbage; the
  // non-blocking assignments keep the bulk copy reading the pre-edge shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (i_we) r_shadow[w_addr] <= i_data;
      if (i_swap) r_active <= r_shadow;
    end
  end

  assign o_active = r_active;

endmodule : fir_coeff_bank

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: fills a shadow bank over valid/ready and commits
// it atomically to the active bank on a filter-granted swap boundary.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int TAPS  = 401,
  parameter int COEFW = DEFAULT_COEFW,
  parameter int IDXW  = $clog2(TAPS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_valid,
  input  logic signed [COEFW-1:0] coef_data,
  input  logic                    coef_last,
  output logic                    coef_ready,
  input  logic                    swap_allow,
  output logic signed [COEFW-1:0] weights_out [0:TAPS-1],
  output logic                    weights_valid,
  output logic                    swap_pulse,
  output logic                    load_error,
  output logic [IDXW-1:0]         load_count
);

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(TAPS - 1);
  localparam logic [IDXW-1:0] FULL_CNT  = IDXW'(TAPS);

  load_state_t     r_state;
  load_state_t     w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idx_nxt;
  logic            r_load_error;
  logic            r_swap_pulse;
  logic            r_weights_valid;
  logic            w_accept;
  logic            w_we;
  logic            w_swap;
  logic            w_err_nxt;

  // Ready is gated by rst so upstream cannot hand over a beat during reset.
  assign coef_ready = ~rst & (r_state != S_PENDING);
  assign w_accept   = coef_valid & coef_ready;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_swap      = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          w_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (coef_last) begin
              w_state_nxt = S_PENDING;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DRAIN;
            end
          end else if (coef_last) begin
            w_err_nxt = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept && coef_last) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
        end
      end
      S_PENDING: begin
        if (swap_allow) begin
          w_swap      = 1'b1;
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_LOAD;
      r_idx           <= '0;
      r_load_error    <= 1'b0;
      r_swap_pulse    <= 1'b0;
      r_weights_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_load_error <= w_err_nxt;
      r_swap_pulse <= w_swap;
      if (w_swap) r_weights_valid <= 1'b1;
    end
  end

  always_comb begin
    load_count = '0;
    unique case (r_state)
      S_LOAD:    load_count = r_idx;
      S_PENDING: load_count = FULL_CNT;
      default:   load_count = '0;
    endcase
  end

  assign load_error    = r_load_error;
  assign swap_pulse    = r_swap_pulse;
  assign weights_valid = r_weights_valid;

  fir_coeff_bank #(
    .TAPS  (TAPS),
    .COEFW (COEFW),
    .IDXW  (IDXW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_idx    (r_idx),
    .i_data   (coef_data),
    .i_swap   (w_swap),
    .o_active (weights_out)
  );

endmodule : fir_coeff_loader

// File: tb/tb_fir_coeff_loader.sv
// Directed plus randomized bench for fir_coeff_loader with TAPS=4; expected
// behaviour comes from a set-level model (set length vs TAPS decides outcome).
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int TAPS  = 4;
  localparam int COEFW = 16;
  localparam int IDXW  = $clog2(TAPS + 1);

  logic                    clk;
  logic                    rst;
  logic                    coef_valid;
  logic signed [COEFW-1:0] coef_data;
  logic                    coef_last;
  logic                    coef_ready;
  logic                    swap_allow;
  logic signed [COEFW-1:0] weights_out [0:TAPS-1];
  logic                    weights_valid;
  logic                    swap_pulse;
  logic                    load_error;
  logic [IDXW-1:0]         load_count;

  fir_coeff_loader #(
    .TAPS  (TAPS),
    .COEFW (COEFW),
    .IDXW  (IDXW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coef_valid    (coef_valid),
    .coef_data     (coef_data),
    .coef_last     (coef_last),
    .coef_ready    (coef_ready),
    .swap_allow    (swap_allow),
    .weights_out   (weights_out),
    .weights_valid (weights_valid),
    .swap_pulse    (swap_pulse),
    .load_error    (load_error),
    .load_count    (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: what the filter should currently see.
  logic signed [COEFW-1:0] m_active [0:TAPS-1];
  bit                      m_valid;
  coef_t                   bq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < TAPS; i++)
      check($sformatf("%s/w%0d", tag, i), 32'($unsigned(weights_out[i])),
            32'($unsigned(m_active[i])));
    check({tag, "/wvalid"}, 32'(weights_valid), 32'(m_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    bq.push_back(coef_t'(v));
  endtask

  function automatic int exp_cnt(input int b);
    return (b < TAPS) ? b : 0;
  endfunction

  // Sends the set held in bq. hold: cycles with swap_allow low while pending;
  // hold < 0 stops in the pending state without granting the swap.
  task automatic send_set(input string name, input int hold, input bit gaps);
    int n;
    bit err;
    n = bq.size();
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          coef_valid = 1'b0;
          coef_data  = coef_t'($urandom);
          coef_last  = 1'($urandom);
          swap_allow = 1'($urandom);
          tick();
          check({name, "/gap_cnt"}, 32'(load_count), 32'(exp_cnt(b)));
          check({name, "/gap_err"}, 32'(load_error), 32'd0);
          check({name, "/gap_swp"}, 32'(swap_pulse), 32'd0);
        end
      end
      coef_valid = 1'b1;
      coef_data  = bq[b];
      coef_last  = (b == n - 1);
      swap_allow = 1'($urandom);
      check($sformatf("%s/rdy%0d", name, b), 32'(coef_ready), 32'd1);
      check($sformatf("%s/cnt%0d", name, b), 32'(load_count), 32'(exp_cnt(b)));
      tick();
      err = ((n < TAPS) && (b == n - 1)) || ((n > TAPS) && (b == TAPS - 1));
      check($sformatf("%s/err%0d", name, b), 32'(load_error), 32'(err));
      check($sformatf("%s/swp%0d", name, b), 32'(swap_pulse), 32'd0);
    end
    coef_valid = 1'b0;
    if (n == TAPS) begin
      swap_allow = (hold == 0);
      check({name, "/pend_rdy"}, 32'(coef_ready), 32'd0);
      check({name, "/pend_cnt"}, 32'(load_count), TAPS);
      check_bank({name, "/pend"});
      if (hold < 0) return;
      for (int h = 0; h < hold; h++) begin
        tick();
        check({name, "/hold_rdy"}, 32'(coef_ready), 32'd0);
        check({name, "/hold_cnt"}, 32'(load_count), TAPS);
        check({name, "/hold_swp"}, 32'(swap_pulse), 32'd0);
        check_bank({name, "/hold"});
      end
      swap_allow = 1'b1;
      tick();
      for (int i = 0; i < TAPS; i++) m_active[i] = bq[i];
      m_valid = 1'b1;
      check({name, "/swp"}, 32'(swap_pulse), 32'd1);
      check({name, "/post_rdy"}, 32'(coef_ready), 32'd1);
      check({name, "/post_cnt"}, 32'(load_count), 32'd0);
      check_bank({name, "/commit"});
      swap_allow = 1'($urandom);
      tick();
      check({name, "/swp_end"}, 32'(swap_pulse), 32'd0);
      check_bank({name, "/after"});
    end else begin
      check({name, "/end_cnt"}, 32'(load_count), 32'd0);
      tick();
      check({name, "/err_end"}, 32'(load_error), 32'd0);
      check({name, "/no_swp"}, 32'(swap_pulse), 32'd0);
      check({name, "/end_rdy"}, 32'(coef_ready), 32'd1);
      check_bank({name, "/unchanged"});
    end
  endtask

  initial begin
    rst        = 1'b1;
    coef_valid = 1'b0;
    coef_data  = '0;
    coef_last  = 1'b0;
    swap_allow = 1'b0;
    for (int i = 0; i < TAPS; i++) m_active[i] = '0;
    m_valid = 1'b0;

    #12;
    check("rst/rdy", 32'(coef_ready), 32'd0);
    check("rst/cnt", 32'(load_count), 32'd0);
    check("rst/err", 32'(load_error), 32'd0);
    check("rst/swp", 32'(swap_pulse), 32'd0);
    check_bank("rst");
    #11 rst = 1'b0;

    swap_allow = 1'b1;
    repeat (3) begin
      tick();
      check("idle/rdy", 32'(coef_ready), 32'd1);
      check("idle/cnt", 32'(load_count), 32'd0);
      check("idle/err", 32'(load_error), 32'd0);
      check("idle/swp", 32'(swap_pulse), 32'd0);
      check_bank("idle");
    end

    bq.delete(); push(1); push(2); push(3); push(-4);
    send_set("nominal", 0, 1'b0);

    bq.delete(); push(5); push(6); push(7); push(8);
    send_set("held", 10, 1'b0);

    bq.delete(); push(9); push(10);
    send_set("short", 0, 1'b0);
    bq.delete(); push(11); push(12); push(13); push(14);
    send_set("after_short", 0, 1'b0);

    bq.delete();
    for (int v = 1; v <= 6; v++) push(v);
    send_set("long", 0, 1'b0);
    bq.delete(); push(20); push(21); push(22); push(23);
    send_set("after_long", 1, 1'b0);

    bq.delete(); push(30); push(31); push(32); push(33);
    send_set("rst_pend", -1, 1'b0);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < TAPS; i++) m_active[i] = '0;
    m_valid = 1'b0;
    check("rst_pend/rdy", 32'(coef_ready), 32'd0);
    check("rst_pend/cnt", 32'(load_count), 32'd0);
    check("rst_pend/swp", 32'(swap_pulse), 32'd0);
    check_bank("rst_pend");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel/rdy", 32'(coef_ready), 32'd1);
    check("rel/cnt", 32'(load_count), 32'd0);
    check_bank("rel");
    bq.delete(); push(40); push(-41); push(42); push(-43);
    send_set("post_rst", 0, 1'b0);

    for (int s = 0; s < 25; s++) begin
      int len;
      len = $urandom_range(1, 10);
      len = (len > 6) ? TAPS : len;
      bq.delete();
      for (int k = 0; k < len; k++) push(int'($urandom));
      send_set($sformatf("rand%0d", s), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_fir_coeff_loader

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Writer side of the FIR filter's coefficient port. It accepts coefficients serially over a valid/ready stream into a shadow bank. On a filter-granted boundary it commits the whole set atomically to the active bank that drives the filter's parallel weight input. The filter therefore never sees a half-updated coefficient set.

Parameters:
TAPS, 401, number of coefficients per set; must match the filter's TAPS.
COEFW, 16, coefficient width in bits (signed, two's complement).
IDXW, $clog2(TAPS+1), width of the load index/count.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
coef_valid  input  1  upstream coefficient beat valid.
coef_data  input  COEFW  coefficient value; first beat of a set is tap 0.
coef_last  input  1  marks the final beat of a set.
coef_ready  output  1  loader can accept a beat this cycle.
swap_allow  input  1  filter permits a bank swap this cycle (sample boundary).
weights_out  output  COEFW x [0:TAPS-1]  active bank, wired to the filter's weight input.
weights_valid  output  1  at least one complete set has been committed since reset.
swap_pulse  output  1  one-cycle strobe in the cycle after the active bank updated.
load_error  output  1  one-cycle strobe on a malformed set.
load_count  output  IDXW  beats accepted into the current set.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - State LOAD, idx=0.
  - Shadow and active banks all zero; weights_valid=0.
  - coef_ready=0 while rst is high; swap_pulse=0, load_error=0, load_count=0.
- Beat accepted when coef_valid & coef_ready at a rising edge. Upstream holds data/last stable until accepted.
- States: LOAD, PENDING, DRAIN.
- LOAD (coef_ready=1):
  - Accepted beat writes shadow[idx].
  - If coef_last and idx==TAPS-1: go to PENDING.
  - If coef_last and idx<TAPS-1 (short set): load_error=1 for one cycle, idx=0, stay in LOAD. The partial shadow content is irrelevant because it will be overwritten.
  - If !coef_last and idx==TAPS-1 (long set): the beat is written, load_error=1 for one cycle, go to DRAIN.
  - Otherwise: idx++.
- DRAIN (coef_ready=1): discard beats until one with coef_last is accepted, then go to LOAD with idx=0. No further load_error in DRAIN.
- PENDING (coef_ready=0):
  - In any cycle with swap_allow=1, the active bank is loaded from shadow at that edge.
  - Same edge: weights_valid=1, idx=0, state LOAD.
  - swap_pulse=1 during the following cycle.
- Latency:
  - Last beat accepted at edge N means the state is PENDING from N.
  - If swap_allow is already high after edge N, the active bank updates at edge N+1 and coef_ready returns high after N+1.
- swap_allow is ignored outside PENDING.
- The active bank changes only on a swap, or to zero on reset.
- load_count = idx in LOAD, TAPS in PENDING, 0 in DRAIN.
- Reset mid-load or mid-PENDING: pending set discarded, active bank zeroed, weights_valid=0.
- No arithmetic on coefficients; bit-exact copy.

Decomposition:
- Package fir_pkg:
  - COEFW default constant.
  - typedef coef_t = logic signed [COEFW-1:0].
  - Loader state enum {LOAD, PENDING, DRAIN}.
- One sub-module, fir_coeff_bank:
  - TAPS-entry register array with an indexed single-entry write (idx, we, data).
  - Bulk copy from shadow to active on swap.
  - Async clear on rst.
  - The loader FSM, index counter and strobes stay in fir_coeff_loader.

Test Plan:
- Bench override TAPS=4.
- Reset then idle: weights_out all 0, weights_valid=0, coef_ready=1 after rst deasserts, no strobes.
- Nominal load: beats 1,2,3,-4 (last on -4), swap_allow held 1 → weights_out={1,2,3,-4} one edge after the last beat; swap_pulse exactly one cycle; weights_valid=1; load_count shows 0,1,2,3 across the beats, then 4 in PENDING.
- Held swap: load 5,6,7,8 with swap_allow=0 for 10 cycles → coef_ready=0, weights_out unchanged ({1,2,3,-4}), upstream stalled. Raise swap_allow → weights_out={5,6,7,8} at the next edge.
- Short set: beats 9,10 with last on 10 → load_error one cycle, weights_out unchanged; a following valid set 11..14 commits correctly.
- Long set: beats 1..6, last on 6 → load_error when beat 4 is accepted, beats 5 and 6 discarded, no swap; the next set 20..23 commits as {20,21,22,23}.
- Reset mid-PENDING: assert rst asynchronously between edges → weights_out=0 and weights_valid=0 immediately; after release, a new load behaves as nominal.
